// File: rtl/hawk_att_lookup.sv
// hawk_att_lookup: one-at-a-time ATT entry fetch over AXI read, decoded into a host page translation.
// Optional single 64B ATT block cache is built when HACD_ATT_BLK_CACHE_EN is defined.
module hawk_att_lookup #(
    parameter logic [63:0] ATT_BASE  = 64'hFFF6100000,
    parameter logic [63:0] HPPA_BASE = 64'hFFF6400000,
    parameter int unsigned ENTRY_CNT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lkup_valid,
    input  logic [51:0]  lkup_hppa,
    output logic         lkup_ready,
    input  logic         att_inv,
    output logic [63:0]  ar_addr,
    output logic         ar_valid,
    input  logic         ar_ready,
    input  logic [511:0] r_data,
    input  logic [1:0]   r_resp,
    input  logic         r_valid,
    input  logic         r_last,
    output logic         r_ready,
    output logic         trnsl_valid,
    output logic [51:0]  trnsl_ppa,
    output logic [1:0]   trnsl_sts,
    output logic [9:0]   trnsl_zpd,
    output logic         trnsl_allow,
    output logic         trnsl_err,
    input  logic         trnsl_ready
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_RWAIT, S_RESP} state_t;

    localparam logic [51:0] HPPA_PG   = HPPA_BASE[63:12];
    localparam logic [51:0] ENTRY_LIM = 52'(ENTRY_CNT);

    state_t      state_q, state_d;
    logic [63:0] ar_addr_q, ar_addr_d;
    logic [2:0]  slot_q, slot_d;
    logic [51:0] ppa_q, ppa_d;
    logic [1:0]  sts_q, sts_d;
    logic [9:0]  zpd_q, zpd_d;
    logic        allow_q, allow_d;
    logic        err_q, err_d;

    logic [51:0]  idx;
    logic [63:0]  ent_addr, blk_addr;
    logic         in_range, cache_hit;
    logic [511:0] src_blk;
    logic [2:0]   src_slot;
    logic [1:0]   src_resp;
    logic [63:0]  entry;
    logic [1:0]   dec_sts;
    logic         dec_err, dec_allow;

`ifdef HACD_ATT_BLK_CACHE_EN
    logic         cache_vld_q, cache_vld_d;
    logic [63:0]  cache_addr_q, cache_addr_d;
    logic [511:0] cache_blk_q, cache_blk_d;
`else
    logic unused_att_inv;
    assign unused_att_inv = att_inv;
`endif

    always_comb begin
        idx      = lkup_hppa - HPPA_PG;
        ent_addr = ATT_BASE + {9'd0, idx, 3'd0};
        blk_addr = ent_addr & ~64'h3F;
        in_range = idx < ENTRY_LIM;

`ifdef HACD_ATT_BLK_CACHE_EN
        // An invalidate in the same cycle as a lookup must not be bypassed by a hit.
        cache_hit = cache_vld_q && !att_inv && (cache_addr_q == blk_addr);
        src_blk   = (state_q == S_IDLE) ? cache_blk_q : r_data;
        src_slot  = (state_q == S_IDLE) ? idx[2:0]    : slot_q;
        src_resp  = (state_q == S_IDLE) ? 2'b00       : r_resp;
`else
        cache_hit = 1'b0;
        src_blk   = r_data;
        src_slot  = slot_q;
        src_resp  = r_resp;
`endif
        entry     = src_blk[64*src_slot +: 64];
        dec_sts   = entry[1:0];
        dec_err   = src_resp != 2'b00;
        dec_allow = !dec_err && (dec_sts == 2'd1 || dec_sts == 2'd3);

        state_d   = state_q;
        ar_addr_d = ar_addr_q;
        slot_d    = slot_q;
        ppa_d     = ppa_q;
        sts_d     = sts_q;
        zpd_d     = zpd_q;
        allow_d   = allow_q;
        err_d     = err_q;
`ifdef HACD_ATT_BLK_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_blk_d  = cache_blk_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (lkup_valid) begin
                    if (!in_range) begin
                        state_d = S_RESP;
                        ppa_d   = '0;
                        sts_d   = '0;
                        zpd_d   = '0;
                        allow_d = 1'b0;
                        err_d   = 1'b1;
                    end else if (cache_hit) begin
                        state_d = S_RESP;
                        zpd_d   = entry[63:54];
                        ppa_d   = entry[53:2];
                        sts_d   = dec_sts;
                        allow_d = dec_allow;
                        err_d   = dec_err;
                    end else begin
                        ar_addr_d = blk_addr;
                        slot_d    = idx[2:0];
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                if (ar_ready) state_d = S_RWAIT;
            end
            S_RWAIT: begin
                // Only the last beat carries the entry; earlier beats are dropped.
                if (r_valid && r_last) begin
                    state_d = S_RESP;
                    zpd_d   = entry[63:54];
                    ppa_d   = entry[53:2];
                    sts_d   = dec_sts;
                    allow_d = dec_allow;
                    err_d   = dec_err;
`ifdef HACD_ATT_BLK_CACHE_EN
                    if (r_resp == 2'b00) begin
                        cache_vld_d  = 1'b1;
                        cache_addr_d = ar_addr_q;
                        cache_blk_d  = r_data;
                    end
`endif
                end
            end
            S_RESP: begin
                if (trnsl_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef HACD_ATT_BLK_CACHE_EN
        if (att_inv) cache_vld_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ar_addr_q <= '0;
            slot_q    <= '0;
            ppa_q     <= '0;
            sts_q     <= '0;
            zpd_q     <= '0;
            allow_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef HACD_ATT_BLK_CACHE_EN
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            cache_blk_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ar_addr_q <= ar_addr_d;
            slot_q    <= slot_d;
            ppa_q     <= ppa_d;
            sts_q     <= sts_d;
            zpd_q     <= zpd_d;
            allow_q   <= allow_d;
            err_q     <= err_d;
`ifdef HACD_ATT_BLK_CACHE_EN
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_blk_q  <= cache_blk_d;
`endif
        end
    end

    assign lkup_ready  = state_q == S_IDLE;
    assign ar_valid    = state_q == S_AR;
    assign ar_addr     = ar_addr_q;
    assign r_ready     = (state_q == S_IDLE) || (state_q == S_RWAIT);
    assign trnsl_valid = state_q == S_RESP;
    assign trnsl_ppa   = ppa_q;
    assign trnsl_sts   = sts_q;
    assign trnsl_zpd   = zpd_q;
    assign trnsl_allow = allow_q;
    assign trnsl_err   = err_q;

endmodule

// File: tb/tb_hawk_att_lookup.sv
// tb_hawk_att_lookup: scoreboard bench; an ATT table model plus AXI slave answer randomized lookups.
`timescale 1ns/1ps
module tb_hawk_att_lookup;
    localparam logic [63:0] ATT_BASE  = 64'hFFF6100000;
    localparam logic [51:0] HPPA_PG   = 52'hFFF6400;
    localparam int          ENTRY_CNT = 8;
`ifdef HACD_ATT_BLK_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1;
    logic         lkup_valid = 1'b0;
    logic [51:0]  lkup_hppa = '0;
    logic         lkup_ready;
    logic         att_inv = 1'b0;
    logic [63:0]  ar_addr;
    logic         ar_valid;
    logic         ar_ready = 1'b0;
    logic [511:0] r_data = '0;
    logic [1:0]   r_resp = '0;
    logic         r_valid = 1'b0, r_last = 1'b0;
    logic         r_ready;
    logic         trnsl_valid;
    logic [51:0]  trnsl_ppa;
    logic [1:0]   trnsl_sts;
    logic [9:0]   trnsl_zpd;
    logic         trnsl_allow, trnsl_err;
    logic         trnsl_ready = 1'b0;

    typedef struct packed {
        logic [51:0] ppa;
        logic [1:0]  sts;
        logic [9:0]  zpd;
        logic        allow;
        logic        err;
    } res_t;
    typedef struct {
        logic [63:0] addr;
        logic [1:0]  resp;
        int          nbeats;
        int          gap;
        bit          stray;
    } axi_t;

    res_t        exp_q[$];
    axi_t        ar_q[$];
    logic [63:0] mem [ENTRY_CNT];
    int          checks = 0, errors = 0;
    bit          rr_en = 1'b0, rdy_force = 1'b1, model_cache_v = 1'b0;

    hawk_att_lookup dut (
        .clk(clk), .rst(rst),
        .lkup_valid(lkup_valid), .lkup_hppa(lkup_hppa), .lkup_ready(lkup_ready),
        .att_inv(att_inv),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
        .trnsl_valid(trnsl_valid), .trnsl_ppa(trnsl_ppa), .trnsl_sts(trnsl_sts),
        .trnsl_zpd(trnsl_zpd), .trnsl_allow(trnsl_allow), .trnsl_err(trnsl_err),
        .trnsl_ready(trnsl_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] att_block();
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < ENTRY_CNT; i++) b[64*i +: 64] = mem[i];
        return b;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Reference: table entry idx lives at ATT_BASE + 8*idx; fields are zpd|ppa|sts.
    task automatic lookup(input logic [51:0] hppa, input logic [1:0] resp, input int gap, input bit stray);
        logic [51:0] idx;
        logic [63:0] ent;
        res_t        e;
        bit          no_ar;
        int          n;
        idx   = hppa - HPPA_PG;
        no_ar = 1'b1;
        e     = '0;
        if (idx >= 52'(ENTRY_CNT)) begin
            e.err = 1'b1;
        end else begin
            ent = mem[int'(idx)];
            if (CACHE_EN && model_cache_v) begin
                resp = 2'b00;
            end else begin
                no_ar = 1'b0;
                ar_q.push_back('{addr: (ATT_BASE + 64'(idx) * 64'd8) & ~64'h3F, resp: resp,
                                 nbeats: int'($urandom_range(1, 3)), gap: gap, stray: stray});
                if (resp == 2'b00 && !stray) model_cache_v = CACHE_EN;
            end
            e.zpd   = ent[63:54];
            e.ppa   = ent[53:2];
            e.sts   = ent[1:0];
            e.err   = resp != 2'b00;
            e.allow = !e.err && (e.sts == 2'd1 || e.sts == 2'd3);
        end
        if (!stray) exp_q.push_back(e);
        @(negedge clk);
        lkup_hppa  = hppa;
        lkup_valid = 1'b1;
        for (n = 0; n < 200 && !lkup_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        lkup_valid = 1'b0;
        chk("accept_timeout", 64'(n < 200), 64'd1);
        chk("lkup_ready_busy", 64'(lkup_ready), 64'd0);
        chk("ar_valid_next", 64'(ar_valid), 64'(!no_ar));
        chk("trnsl_valid_next", 64'(trnsl_valid), 64'(no_ar));
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 100 && !trnsl_valid; n++) begin @(posedge clk); #1; end
        chk("valid_timeout", 64'(trnsl_valid), 64'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300 && !(lkup_ready && exp_q.size() == 0); n++) begin @(posedge clk); #1; end
    endtask

    task automatic invalidate();
        @(negedge clk); att_inv = 1'b1;
        @(negedge clk); att_inv = 1'b0;
        model_cache_v = 1'b0;
    endtask

    // AXI read slave: answers each AR from the plan queue, filler beats first, entry block last.
    initial forever begin
        @(negedge clk);
        if (ar_valid) begin
            axi_t a;
            if (ar_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ar: got addr %0h expected no AR", ar_addr);
                a = '{addr: ar_addr, resp: 2'b00, nbeats: 1, gap: 0, stray: 1'b1};
            end else begin
                a = ar_q.pop_front();
                chk("ar_addr", ar_addr, a.addr);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("ar_stable", ar_valid ? ar_addr : 64'hDEAD, a.addr);
            end
            ar_ready = 1'b1;
            @(negedge clk);
            ar_ready = 1'b0;
            repeat (a.gap) @(negedge clk);
            for (int b = 0; b < a.nbeats; b++) begin
                r_valid = 1'b1;
                r_last  = b == a.nbeats - 1;
                r_resp  = r_last ? a.resp : 2'($urandom);
                r_data  = r_last ? att_block() : rand_block();
                @(posedge clk); #1;
                if (r_last && !a.stray) chk("lat_resp", 64'(trnsl_valid), 64'd1);
                @(negedge clk);
                r_valid = 1'b0;
                r_last  = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk); #2;
        trnsl_ready = rr_en ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && trnsl_valid && trnsl_ready) begin
            res_t act, exp;
            act = {trnsl_ppa, trnsl_sts, trnsl_zpd, trnsl_allow, trnsl_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h expected no result", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL result: got ppa=%h sts=%0d zpd=%h allow=%b err=%b expected ppa=%h sts=%0d zpd=%h allow=%b err=%b",
                             act.ppa, act.sts, act.zpd, act.allow, act.err,
                             exp.ppa, exp.sts, exp.zpd, exp.allow, exp.err);
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t snap;
        logic [51:0] hppa;
        logic [1:0]  resp;
        for (int i = 0; i < ENTRY_CNT; i++) mem[i] = {$urandom, $urandom};
        mem[3] = 64'h0000_0000_0020_0015;

        repeat (3) @(posedge clk); #1;
        chk("rst_lkup_ready", 64'(lkup_ready), 64'd1);
        chk("rst_ar_valid", 64'(ar_valid), 64'd0);
        chk("rst_r_ready", 64'(r_ready), 64'd1);
        chk("rst_trnsl_valid", 64'(trnsl_valid), 64'd0);
        chk("rst_ar_addr", ar_addr, 64'd0);
        chk("rst_ppa", 64'(trnsl_ppa), 64'd0);
        chk("rst_flags", 64'({trnsl_sts, trnsl_zpd, trnsl_allow, trnsl_err}), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Reset while waiting for read data; the late beat must be swallowed in IDLE.
        lookup(HPPA_PG + 52'd1, 2'b00, 4, 1'b1);
        for (int n = 0; n < 20 && ar_valid; n++) begin @(posedge clk); #1; end
        chk("rwait_r_ready", 64'(r_ready), 64'd1);
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_mid_state", 64'({trnsl_valid, ar_valid, lkup_ready}), 64'b001);
        chk("rst_mid_ar_addr", ar_addr, 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("stray_no_result", 64'({trnsl_valid, r_ready}), 64'b01);
        end

        lookup(HPPA_PG + 52'd8, 2'b00, 0, 1'b0);
        chk("oor_err_allow", 64'({trnsl_err, trnsl_allow}), 64'b10);
        wait_idle();

        rdy_force = 1'b0;
        lookup(HPPA_PG + 52'd3, 2'd2, 0, 1'b0);
        chk("slverr_ar_addr", ar_addr, 64'hFFF6100000);
        wait_valid();
        snap = {trnsl_ppa, trnsl_sts, trnsl_zpd, trnsl_allow, trnsl_err};
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_ppa", 64'(trnsl_ppa), 64'(snap.ppa));
            chk("stall_flags", 64'({trnsl_valid, lkup_ready, trnsl_sts, trnsl_zpd, trnsl_allow, trnsl_err}),
                64'({2'b10, snap.sts, snap.zpd, snap.allow, snap.err}));
        end
        chk("slverr_ppa", 64'(trnsl_ppa), 64'h80005);
        chk("slverr_err_allow", 64'({trnsl_err, trnsl_allow}), 64'b10);
        rdy_force = 1'b1;
        wait_idle();

        lookup(HPPA_PG + 52'd3, 2'b00, 0, 1'b0);
        chk("ok_ar_addr", ar_addr, 64'hFFF6100000);
        wait_valid();
        chk("ok_ppa", 64'(trnsl_ppa), 64'h80005);
        chk("ok_fields", 64'({trnsl_sts, trnsl_zpd, trnsl_allow, trnsl_err}), 64'({2'd1, 10'd0, 1'b1, 1'b0}));
        wait_idle();

        lookup(HPPA_PG + 52'd3, 2'b00, 0, 1'b0);
        wait_valid();
        chk("repeat_ppa", 64'(trnsl_ppa), 64'h80005);
        wait_idle();
        invalidate();
        lookup(HPPA_PG + 52'd5, 2'b00, 0, 1'b0);
        wait_idle();

        rr_en = 1'b1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0:       hppa = HPPA_PG - 52'd1;
                1:       hppa = 52'({$urandom, $urandom});
                default: hppa = HPPA_PG + 52'($urandom_range(0, 9));
            endcase
            resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            lookup(hppa, resp, int'($urandom_range(0, 2)), 1'b0);
            if ($urandom_range(0, 15) == 0) begin
                wait_idle();
                invalidate();
            end
        end
        wait_idle();
        rr_en = 1'b0;
        chk("drain_results", 64'(exp_q.size()), 64'd0);
        chk("drain_ar", 64'(ar_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
